seven_segment_scan_encoder: RTL and testbench

SEVEN_SEGMENT_SCAN_ENCODER -- requirements
Module: seven_segment_scan_encoder

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg_pattern_to_nibble.sv | 41 ++++
 rtl/seven_segment_scan_encoder.sv | 163 ++++++++++++++++
 tb/tb_seven_segment_scan_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan encoder.
//  - STABLE_CYCLES_DEFAULT : default number of identical sampled cycles before a capture
//  - SEG_0 .. SEG_F        : segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//  - state_t / ST_*        : scan FSM state encoding
package seg7_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h67;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_HELD   = 2'd2;

endpackage

// File: rtl/seg_pattern_to_nibble.sv
// Combinational decoder from a seven-segment pattern to a hex nibble.
//  - pattern_i : segment lines {g,f,e,d,c,b,a}, active-high
//  - nibble_o  : decoded value (0 when the pattern is not recognised)
//  - err_o     : 1 when the pattern is not one of the 16 hex glyphs
module seg_pattern_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       err_o
);

    // Glyph lookup; anything outside the table is flagged as an error.
    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b0;
        case (pattern_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: begin
                nibble_o = 4'h0;
                err_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_encoder.sv
// Recovers a 4-digit hex value from a multiplexed seven-segment display bus.
// A digit is captured once {anIn,ssIn} has been sampled identical for
// STABLE_CYCLES consecutive edges with a one-hot anIn. When all four digits
// have been captured, the frame is published on the following edge.
//  - clk      : clock, rising edge
//  - rstN     : asynchronous active-low reset
//  - ssIn     : segment lines {g,f,e,d,c,b,a}
//  - anIn     : digit strobes, bit i selects digit i
//  - valueOut : last complete frame, digit i in bits [4i+3:4i]
//  - errOut   : per-digit unrecognised-pattern flags of that frame
//  - validOut : one-cycle pulse when valueOut/errOut update
module seven_segment_scan_encoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [6:0]  ssIn,
    input  logic [3:0]  anIn,
    output logic [15:0] valueOut,
    output logic [3:0]  errOut,
    output logic        validOut
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] prev_q;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] slots_q, slots_d;
    logic [3:0]  slot_err_q, slot_err_d;
    logic [15:0] value_q;
    logic [3:0]  err_q;
    logic        valid_q;

    logic        onehot_s;
    logic        same_s;
    logic        capture_s;
    logic        frame_load_s;
    logic [1:0]  idx_s;
    logic [3:0]  nibble_s;
    logic        pat_err_s;

    seg_pattern_to_nibble u_decode (
        .pattern_i (ssIn),
        .nibble_o  (nibble_s),
        .err_o     (pat_err_s)
    );

    assign onehot_s     = $onehot(anIn);
    assign same_s       = ({anIn, ssIn} == prev_q);
    // seenMask is only ever full for the single cycle between the last capture and the load.
    assign frame_load_s = (seen_q == 4'hF);

    // Slot index of the strobed digit; only used when anIn is one-hot.
    always_comb begin
        idx_s = 2'd0;
        case (anIn)
            4'b0001: idx_s = 2'd0;
            4'b0010: idx_s = 2'd1;
            4'b0100: idx_s = 2'd2;
            4'b1000: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
    end

    // Scan FSM next state, stability counter and capture decision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (onehot_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            ST_SETTLE: begin
                if (!onehot_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (same_s) begin
                    cnt_d   = (cnt_q < STABLE_C) ? cnt_q + 8'd1 : cnt_q;
                end else begin
                    cnt_d   = 8'd1;
                end
            end
            ST_HELD: begin
                if (same_s) begin
                    state_d = ST_HELD;
                end else if (onehot_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // Reaching the threshold while settling captures the digit and parks in HELD.
        if ((state_d == ST_SETTLE) && (cnt_d == STABLE_C)) begin
            capture_s = 1'b1;
            state_d   = ST_HELD;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Slot and seen-mask update; a capture on the load edge belongs to the next frame.
    always_comb begin
        slots_d    = slots_q;
        slot_err_d = slot_err_q;
        seen_d     = frame_load_s ? 4'h0 : seen_q;
        if (capture_s) begin
            slots_d[{idx_s, 2'b00} +: 4] = nibble_s;
            slot_err_d[idx_s]            = pat_err_s;
            seen_d                       = seen_d | anIn;
        end else begin
            seen_d = seen_d;
        end
    end

    // State registers and published frame.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            prev_q     <= 11'd0;
            seen_q     <= 4'h0;
            slots_q    <= 16'h0000;
            slot_err_q <= 4'h0;
            value_q    <= 16'h0000;
            err_q      <= 4'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= {anIn, ssIn};
            seen_q     <= seen_d;
            slots_q    <= slots_d;
            slot_err_q <= slot_err_d;
            valid_q    <= frame_load_s;
            if (frame_load_s) begin
                value_q <= slots_q;
                err_q   <= slot_err_q;
            end
        end
    end

    assign valueOut = value_q;
    assign errOut   = err_q;
    assign validOut = valid_q;

endmodule

// File: tb/tb_seven_segment_scan_encoder.sv
module tb_seven_segment_scan_encoder;

    localparam int STABLE = 4;

    logic        clk;
    logic        rstN;
    logic [6:0]  ssIn;
    logic [3:0]  anIn;
    logic [15:0] valueOut;
    logic [3:0]  errOut;
    logic        validOut;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    // Reference model state: digits are captured when the same one-hot input
    // has been seen for exactly STABLE consecutive edges.
    logic [6:0]  pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_serr;
    logic [3:0]  m_seen;
    bit          m_pend;
    logic [15:0] exp_value;
    logic [3:0]  exp_err;
    logic        exp_valid;

    seven_segment_scan_encoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .ssIn     (ssIn),
        .anIn     (anIn),
        .valueOut (valueOut),
        .errOut   (errOut),
        .validOut (validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_prev = 11'd0; m_run = 0; m_serr = 4'h0; m_seen = 4'h0; m_pend = 1'b0;
        for (int k = 0; k < 4; k++) m_slot[k] = 4'h0;
        exp_value = 16'h0000; exp_err = 4'h0; exp_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic [10:0] cur;
        int          idx;
        logic [3:0]  nib;
        logic        e;
        cur = {anIn, ssIn};
        exp_valid = m_pend;
        if (m_pend) begin
            exp_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            exp_err   = m_serr;
            m_seen    = 4'h0;
            m_pend    = 1'b0;
        end
        if ($onehot(anIn)) m_run = (cur == m_prev && m_run > 0) ? m_run + 1 : 1;
        else               m_run = 0;
        m_prev = cur;
        if (m_run == STABLE) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (anIn[k]) idx = k;
            nib = 4'h0; e = 1'b1;
            for (int k = 0; k < 16; k++) if (pat[k] == ssIn) begin nib = 4'(k); e = 1'b0; end
            m_slot[idx] = nib;
            m_serr[idx] = e;
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) m_pend = 1'b1;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input logic [3:0] an, input logic [6:0] ss);
        anIn = an; ssIn = ss;
        @(posedge clk); #1;
        model_edge();
        if (validOut === 1'b1) pulses++;
        n_checks++;
        if (validOut !== exp_valid) begin
            n_errors++; $display("FAIL validOut @%0t: got %b expected %b", $time, validOut, exp_valid);
        end
        n_checks++;
        if (valueOut !== exp_value) begin
            n_errors++; $display("FAIL valueOut @%0t: got %h expected %h", $time, valueOut, exp_value);
        end
        n_checks++;
        if (errOut !== exp_err) begin
            n_errors++; $display("FAIL errOut @%0t: got %b expected %b", $time, errOut, exp_err);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] ss, input int n);
        for (int i = 0; i < n; i++) step(an, ss);
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rstN = 1'b0; anIn = 4'h0; ssIn = 7'h00;
        #1;
        n_checks++;
        if (valueOut !== 16'h0000 || errOut !== 4'h0 || validOut !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got value=%h err=%b valid=%b expected 0000/0000/0", valueOut, errOut, validOut);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic check_frame(input string name, input int exp_pulses,
                               input logic [15:0] val, input logic [3:0] err);
        n_checks++;
        if (pulses != exp_pulses) begin
            n_errors++; $display("FAIL %s_pulses: got %0d expected %0d", name, pulses, exp_pulses);
        end
        n_checks++;
        if (valueOut !== val) begin
            n_errors++; $display("FAIL %s_value: got %h expected %h", name, valueOut, val);
        end
        n_checks++;
        if (errOut !== err) begin
            n_errors++; $display("FAIL %s_err: got %b expected %b", name, errOut, err);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        pulses = 0;
        // First edge after release sees a fresh previous-input register.
        hold(4'b0001, 7'h3F, 3);
        hold(4'b0000, 7'h00, 2);
        check_frame("reset_idle", 0, 16'h0000, 4'h0);
    endtask

    task automatic test_basic_frame();
        pulses = 0;
        hold(4'b1000, 7'h7F, 6);
        hold(4'b0100, 7'h5B, 6);
        hold(4'b0010, 7'h06, 6);
        hold(4'b0001, 7'h71, 6);
        check_frame("basic", 1, 16'h821F, 4'h0);
    endtask

    task automatic test_glitch_restart();
        pulses = 0;
        hold(4'b0001, 7'h3F, 3);
        hold(4'b0001, 7'h06, 4);
        hold(4'b1000, 7'h3F, 5);
        hold(4'b0100, 7'h66, 5);
        hold(4'b0010, 7'h6D, 5);
        check_frame("glitch", 1, 16'h0451, 4'h0);
    endtask

    task automatic test_bad_pattern();
        pulses = 0;
        hold(4'b1000, 7'h06, 5);
        hold(4'b0100, 7'h49, 5);
        hold(4'b0010, 7'h4F, 5);
        hold(4'b0001, 7'h66, 5);
        check_frame("bad_pattern", 1, 16'h1034, 4'b0100);
    endtask

    task automatic test_not_onehot();
        pulses = 0;
        hold(4'b0011, 7'h3F, 20);
        hold(4'b1000, 7'h07, 5);
        hold(4'b0100, 7'h7D, 5);
        hold(4'b0010, 7'h6D, 5);
        hold(4'b0001, 7'h66, 5);
        check_frame("not_onehot", 1, 16'h7654, 4'h0);
    endtask

    task automatic test_reset_mid_frame();
        hold(4'b1000, 7'h06, 5);
        hold(4'b0100, 7'h5B, 5);
        hold(4'b0010, 7'h4F, 5);
        hold(4'b0001, 7'h3F, 2);
        apply_reset();
        pulses = 0;
        hold(4'b0001, 7'h66, 6);
        hold(4'b0000, 7'h00, 4);
        check_frame("reset_mid", 0, 16'h0000, 4'h0);
    endtask

    task automatic test_resend();
        pulses = 0;
        hold(4'b0001, 7'h77, 6);
        hold(4'b0001, 7'h5E, 6);
        hold(4'b0010, 7'h39, 6);
        hold(4'b0100, 7'h7C, 6);
        hold(4'b1000, 7'h79, 6);
        check_frame("resend", 1, 16'hEBCD, 4'h0);
    endtask

    task automatic test_random();
        logic [3:0] an;
        logic [6:0] ss;
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 9) < 8) an = 4'(4'b0001 << $urandom_range(0, 3));
            else                          an = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 7) ss = pat[$urandom_range(0, 15)];
            else                          ss = 7'($urandom_range(0, 127));
            hold(an, ss, $urandom_range(1, 8));
        end
    endtask

    initial begin
        rstN = 1'b1; anIn = 4'h0; ssIn = 7'h00;
        model_reset();
        #3;
        test_reset();
        test_basic_frame();
        test_glitch_restart();
        test_bad_pattern();
        test_not_onehot();
        test_reset_mid_frame();
        test_resend();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
